aer_decoder_layer1_slice10: RTL and testbench
=============================================

# aer_decoder_layer1_slice10

Receiving end of the layer-1 10-lane AER link. Takes the per-cycle address events produced by the slice-10 AER encoder and rebuilds the 980-bit hot vector of one frame. The block undoes the encoder's error-class lane rotation, validates every event, counts unique spikes, and signals frame completion. It sits at the downstream core input, between the AER link and the layer-1 spike buffer.

## Interface
- N_LANE, 10, number of AER lanes
- N_BIT, 980, hot-vector width
- AER_W, 10, address width per lane
- CNT_W, 10, unique-spike counter width
- clk  input  1  rising-edge clock; the block uses only this clock
- reset  input  1  reset; synchronous and active-high
- start_i  input  1  begin a new frame: clear the vector, count and error flag; latch error_class_i
- error_class_i  input  4  lane rotation amount applied by the encoder; values above 9 are treated as 0
- aer_i  input  N_LANE*AER_W  lane p carried on bits [p*10+9 : p*10]
- valid_i  input  N_LANE  per-lane event valid
- frame_end_i  input  1  controller indicates that the encoder has drained
- hot_vector_o  output  N_BIT  reconstructed frame
- spike_count_o  output  CNT_W  number of distinct bits set in the current frame
- busy_o  output  1  high while in COLLECT
- done_o  output  1  one-cycle pulse when the frame is complete
- err_o  output  1  sticky flag: at least one event was dropped as invalid

## Operation
- FSM states:
  - IDLE: events are ignored.
  - COLLECT: events are applied.
  - DONE: one cycle, then returns to IDLE.
- start_i:
  - Accepted in any state.
  - Clears hot_vector_o, spike_count_o and err_o.
  - Latches the class c.
  - Next state is COLLECT.
  - start_i has priority over valid_i and frame_end_i in the same cycle; events in that cycle are dropped.
- Lane un-rotation: physical lane p carries logical lane q = (p + 10 - c) mod 10.
- Per-lane event acceptance (COLLECT only). A lane's event is accepted only when all of the following hold:
  - valid_i[p] is high.
  - aer < 980.
  - The lane check passes (see Configuration).
- Rejected events with valid_i high set err_o. Events arriving in IDLE or DONE are ignored and do not set err_o.
- An accepted event sets hot_vector bit [aer]. Repeated addresses are idempotent; the encoder repeats addresses on held lanes.
- spike_count_o increments by the number of accepted lanes in the cycle that meet both conditions:
  - The target bit was 0 before this cycle.
  - No lower-index lane in the same cycle carries the same address.
- spike_count_o saturates at 980.
- frame_end_i in COLLECT: events in that same cycle are still applied, and the next state is DONE.
- frame_end_i outside COLLECT is ignored.
- hot_vector_o, spike_count_o and err_o hold their values through DONE and IDLE until the next start_i.

## Timing
- Reset values:
  - state = IDLE
  - hot_vector_o = 0
  - spike_count_o = 0
  - busy_o = 0
  - done_o = 0
  - err_o = 0
- Reset asserted mid-frame aborts the frame; all outputs return to their reset values on the next edge.
- An event accepted in cycle t is visible on hot_vector_o and spike_count_o in cycle t+1.
- busy_o is high from the cycle after start_i until the cycle after frame_end_i.
- done_o is high in the cycle after frame_end_i is sampled. busy_o is 0 in that cycle.
- start_i in cycle t sets busy_o=1 and clears the outputs in cycle t+1.
- start_i coinciding with done_o restarts immediately; there is no IDLE cycle.
- err_o updates one cycle after the offending event.

## Configuration
- AER_DEC_LANE_CHECK_EN defined:
  - Each accepted event must additionally satisfy aer mod 10 == q, the logical lane of its physical lane under class c.
  - Mismatching events are dropped and set err_o.
- AER_DEC_LANE_CHECK_EN undefined:
  - Only the range check applies; any in-range address is accepted on any lane.
  - The same-cycle duplicate rule above still governs counting.

## Structure
- Shared package aer_dec_pkg holds:
  - constants N_LANE, N_BIT, AER_W, CNT_W
  - the FSM state enum (IDLE, COLLECT, DONE)
  - the un-rotation function mapping (p, c) to q
- One sub-module, aer_lane_check, instantiated N_LANE times.
  - Combinational per-lane validation: range check, plus the residue check under the macro.
  - Outputs: accept and reject.
- Top level contains the FSM, the 980-bit register with set logic, the new-bit popcount and the saturating counter.

## Test plan
- Reset, then start_i with c=0. Lane 0 carries aer=0, lane 3 carries aer=13, lane 9 carries aer=979, all in one cycle. Then frame_end_i. Required: bits 0, 13 and 979 set; spike_count_o=3; done_o pulses one cycle after frame_end_i; err_o=0.
- start_i with c=2. Physical lane 2 carries aer=20, physical lane 0 carries aer=8. Required: both accepted, count=2. Same frame, physical lane 0 carries aer=10. Required with the macro: dropped and err_o=1. Required without the macro: bit 10 set and count=3.
- Lane 5 repeats aer=45 for 4 consecutive cycles. Required: bit 45 set and spike_count_o=1.
- Lane 1 carries aer=991 with valid high. Required: event dropped and err_o=1 on the next cycle; vector unchanged.
- start_i asserted together with valid_i=10'h3FF. Required: no bits set; busy_o=1 next cycle. Second start_i mid-frame. Required: vector cleared and count=0.
- Reset asserted in COLLECT with 50 bits set. Required: every output is 0 on the next edge; later events without start_i are ignored.

Source files
------------

// File: rtl/aer_dec_pkg.sv
// Shared constants, FSM state type and lane un-rotation helpers for the
// layer-1 slice-10 AER decoder.
// Optional feature macro: AER_DEC_LANE_CHECK_EN (per-lane address residue check).
package aer_dec_pkg;

  localparam int N_LANE = 10;
  localparam int N_BIT  = 980;
  localparam int AER_W  = 10;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Classes outside 0..9 carry no rotation.
  function automatic logic [3:0] class_norm(input logic [3:0] c);
    return (c > 4'd9) ? 4'd0 : c;
  endfunction

  // Physical lane p carries logical lane (p + 10 - c) mod 10; c must be normalised.
  function automatic logic [3:0] unrotate(input int p, input logic [3:0] c);
    int s;
    s = p + N_LANE - int'(c);
    return 4'(s % N_LANE);
  endfunction

endpackage

// File: rtl/aer_decoder_layer1_slice10_if.sv
// Event-side bus of the AER decoder: frame control plus the 10 address lanes.
// Optional feature macro: AER_DEC_LANE_CHECK_EN (no effect on this file).
interface aer_decoder_layer1_slice10_if
  import aer_dec_pkg::*;
  ;
  logic                    start_i;
  logic [3:0]              error_class_i;
  logic [N_LANE*AER_W-1:0] aer_i;
  logic [N_LANE-1:0]       valid_i;
  logic                    frame_end_i;

  modport master (
    output start_i, error_class_i, aer_i, valid_i, frame_end_i
  );

  modport slave (
    input start_i, error_class_i, aer_i, valid_i, frame_end_i
  );
endinterface

// File: rtl/aer_lane_check.sv
// Combinational validation of one AER lane: range check and, when
// AER_DEC_LANE_CHECK_EN is defined, the address residue must equal the
// logical lane index.
module aer_lane_check
  import aer_dec_pkg::*;
(
  input  logic             en,
  input  logic             valid,
  input  logic [AER_W-1:0] aer,
  input  logic [3:0]       lane_q,
  output logic             accept,
  output logic             reject
);

  logic in_range;
  logic lane_ok;

  assign in_range = (aer < AER_W'(N_BIT));

`ifdef AER_DEC_LANE_CHECK_EN
  assign lane_ok = (4'(aer % AER_W'(N_LANE)) == lane_q);
`else
  logic unused_lane_q;
  assign unused_lane_q = ^lane_q;
  assign lane_ok       = 1'b1;
`endif

  // Events only count while the decoder is collecting.
  always_comb begin
    accept = en && valid && in_range && lane_ok;
    reject = en && valid && !(in_range && lane_ok);
  end

endmodule

// File: rtl/aer_decoder_layer1_slice10.sv
// Layer-1 slice-10 AER decoder: rebuilds the 980-bit hot vector of a frame
// from rotated address lanes, counts distinct spikes and flags bad events.
// Optional feature macro: AER_DEC_LANE_CHECK_EN (per-lane residue check).
module aer_decoder_layer1_slice10
  import aer_dec_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  aer_decoder_layer1_slice10_if.slave bus,
  output logic [N_BIT-1:0]            hot_vector_o,
  output logic [CNT_W-1:0]            spike_count_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  state_t             state_q;
  logic [3:0]         class_q;
  logic               lane_en;
  logic [AER_W-1:0]   lane_aer [N_LANE];
  logic [N_LANE-1:0]  accept;
  logic [N_LANE-1:0]  reject;
  logic [N_BIT-1:0]   set_mask;
  logic [3:0]         new_cnt;
  logic               dup;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   cnt_next;

  // start_i preempts any events presented in the same cycle.
  assign lane_en = (state_q == COLLECT) && !bus.start_i;

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    assign lane_aer[g] = bus.aer_i[g*AER_W +: AER_W];

    aer_lane_check u_chk (
      .en     (lane_en),
      .valid  (bus.valid_i[g]),
      .aer    (lane_aer[g]),
      .lane_q (unrotate(g, class_q)),
      .accept (accept[g]),
      .reject (reject[g])
    );
  end

  // Build the set mask and count bits that become newly set this cycle,
  // crediting a repeated address only to its lowest accepted lane.
  always_comb begin
    set_mask = '0;
    new_cnt  = '0;
    dup      = 1'b0;
    for (int p = 0; p < N_LANE; p++) begin
      dup = 1'b0;
      for (int j = 0; j < N_LANE; j++) begin
        if (j < p && accept[j] && lane_aer[j] == lane_aer[p]) dup = 1'b1;
      end
      if (accept[p]) begin
        set_mask[lane_aer[p]] = 1'b1;
        if (!hot_vector_o[lane_aer[p]] && !dup) new_cnt = new_cnt + 4'd1;
      end
    end
  end

  // Saturating spike counter update.
  always_comb begin
    cnt_sum  = {1'b0, spike_count_o} + (CNT_W+1)'(new_cnt);
    cnt_next = (cnt_sum > (CNT_W+1)'(N_BIT)) ? CNT_W'(N_BIT) : cnt_sum[CNT_W-1:0];
  end

  // Frame FSM with registered status outputs and the frame state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      class_q       <= '0;
      hot_vector_o  <= '0;
      spike_count_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else if (bus.start_i) begin
      state_q       <= COLLECT;
      class_q       <= class_norm(bus.error_class_i);
      hot_vector_o  <= '0;
      spike_count_o <= '0;
      busy_o        <= 1'b1;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          hot_vector_o  <= hot_vector_o | set_mask;
          spike_count_o <= cnt_next;
          if (|reject) err_o <= 1'b1;
          if (bus.frame_end_i) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aer_decoder_layer1_slice10.sv
// Directed bench for the layer-1 slice-10 AER decoder.
// Optional feature macro: AER_DEC_LANE_CHECK_EN (selects expected values).
module tb_aer_decoder_layer1_slice10;
  import aer_dec_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aer_decoder_layer1_slice10_if bus();

  logic [N_BIT-1:0] hot;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic             err;

  aer_decoder_layer1_slice10 dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .hot_vector_o  (hot),
    .spike_count_o (cnt),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  int checks   = 0;
  int failures = 0;
  logic [N_BIT-1:0] exp_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.start_i       = 1'b0;
    bus.error_class_i = 4'd0;
    bus.aer_i         = '0;
    bus.valid_i       = '0;
    bus.frame_end_i   = 1'b0;
  endtask

  task automatic lane(input int p, input int a);
    bus.aer_i[p*AER_W +: AER_W] = AER_W'(a);
    bus.valid_i[p]              = 1'b1;
  endtask

  task automatic start(input int c);
    bus.start_i       = 1'b1;
    bus.error_class_i = 4'(c);
    step();
    idle_in();
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_vec", hot == '0, 1);
    reset = 1'b0;

    // Frame 1: class 0, three lanes at once including the top address.
    start(0);
    chk("t1_busy", busy, 1);
    lane(0, 0); lane(3, 13); lane(9, 979);
    step();
    idle_in();
    exp_vec = '0; exp_vec[0] = 1'b1; exp_vec[13] = 1'b1; exp_vec[979] = 1'b1;
    chk("t1_vec", hot == exp_vec, 1);
    chk("t1_cnt", cnt, 3);
    bus.frame_end_i = 1'b1;
    step();
    idle_in();
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_err", err, 0);
    step();
    chk("t1_done_low", done, 0);
    chk("t1_cnt_hold", cnt, 3);
    lane(1, 991);
    step();
    idle_in();
    chk("idle_err", err, 0);
    chk("idle_vec", hot == exp_vec, 1);

    // Frame 2: class 2 rotation.
    start(2);
    lane(2, 20); lane(0, 8);
    step();
    idle_in();
    chk("t2_cnt", cnt, 2);
    chk("t2_bit20", hot[20], 1);
    chk("t2_bit8", hot[8], 1);
    lane(0, 10);
    step();
    idle_in();
`ifdef AER_DEC_LANE_CHECK_EN
    chk("t2_err", err, 1);
    chk("t2_cnt_b", cnt, 2);
    chk("t2_bit10", hot[10], 0);
`else
    chk("t2_err", err, 0);
    chk("t2_cnt_b", cnt, 3);
    chk("t2_bit10", hot[10], 1);
`endif
    // Restart on the same cycle as the done pulse.
    bus.frame_end_i = 1'b1;
    step();
    idle_in();
    chk("t2_done", done, 1);
    bus.start_i = 1'b1;
    step();
    idle_in();
    chk("rs_busy", busy, 1);
    chk("rs_done", done, 0);
    chk("rs_cnt", cnt, 0);
    chk("rs_err", err, 0);

    // Held lane repeats the same address.
    for (int k = 0; k < 4; k++) begin
      lane(5, 45);
      step();
    end
    idle_in();
    exp_vec = '0; exp_vec[45] = 1'b1;
    chk("t3_cnt", cnt, 1);
    chk("t3_vec", hot == exp_vec, 1);

    // Out-of-range address.
    lane(1, 991);
    step();
    idle_in();
    chk("t4_err", err, 1);
    chk("t4_vec", hot == exp_vec, 1);
    chk("t4_cnt", cnt, 1);

`ifndef AER_DEC_LANE_CHECK_EN
    // Same address on two lanes in one cycle counts once.
    lane(0, 77); lane(4, 77);
    step();
    idle_in();
    chk("dup_cnt", cnt, 2);
    chk("dup_bit", hot[77], 1);
`endif

    // start_i with all lanes valid drops those events.
    bus.start_i = 1'b1;
    for (int p = 0; p < N_LANE; p++) lane(p, p);
    step();
    idle_in();
    chk("t5_busy", busy, 1);
    chk("t5_cnt", cnt, 0);
    chk("t5_vec", hot == '0, 1);
    for (int p = 0; p < N_LANE; p++) lane(p, p);
    step();
    idle_in();
    chk("t5_cnt_b", cnt, 10);
    start(0);
    chk("t5_clear_vec", hot == '0, 1);
    chk("t5_clear_cnt", cnt, 0);

    // Full fill with an out-of-range class (treated as no rotation).
    start(12);
    for (int k = 0; k < 98; k++) begin
      for (int p = 0; p < N_LANE; p++) lane(p, 10*k + p);
      step();
    end
    idle_in();
    chk("fill_cnt", cnt, 980);
    chk("fill_vec", hot == {N_BIT{1'b1}}, 1);
    chk("fill_err", err, 0);
    for (int p = 0; p < N_LANE; p++) lane(p, 100 + p);
    step();
    idle_in();
    chk("fill_sat", cnt, 980);

    // Reset mid-frame with 50 bits set.
    start(0);
    for (int k = 0; k < 5; k++) begin
      for (int p = 0; p < N_LANE; p++) lane(p, 10*k + p);
      step();
    end
    idle_in();
    chk("t6_cnt", cnt, 50);
    reset = 1'b1;
    lane(3, 3);
    step();
    idle_in();
    chk("t6_vec", hot == '0, 1);
    chk("t6_cnt0", cnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_err", err, 0);
    reset = 1'b0;
    lane(2, 2); lane(7, 999);
    step();
    step();
    idle_in();
    chk("t6_post_vec", hot == '0, 1);
    chk("t6_post_cnt", cnt, 0);
    chk("t6_post_err", err, 0);
    chk("t6_post_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
